// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with same-cycle hits and a
// word-by-word line fill over a cs/ack handshake to instruction memory.
module inst_cache #(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_stall,
    input  logic        flush,
    output logic        mem_cs,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int O = $clog2(LINE_WORDS);
    localparam int I = $clog2(LINES);
    localparam int T = 30 - O - I;

    typedef enum logic {IDLE, FILL} state_t;

    typedef struct packed {
        logic [T-1:0] tag;
        logic [I-1:0] idx;
        logic [O-1:0] cnt;
    } fill_t;

    state_t         state, state_nxt;
    fill_t          fill;
    logic           pend;
    logic [LINES-1:0] valid;
    logic [T-1:0]   tag_mem  [LINES];
    logic [31:0]    data_mem [LINES][LINE_WORDS];

    logic [O-1:0]   a_off;
    logic [I-1:0]   a_idx;
    logic [T-1:0]   a_tag;
    logic           hit, miss, last;
    logic           addr_unused;

    assign a_off       = inst_addr[O+1:2];
    assign a_idx       = inst_addr[O+I+1:O+2];
    assign a_tag       = inst_addr[31:O+I+2];
    assign addr_unused = ^inst_addr[1:0];

    assign hit  = inst_ren & valid[a_idx] & (tag_mem[a_idx] == a_tag);
    assign miss = inst_ren & ~hit;
    assign last = mem_ack & (fill.cnt == O'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss) state_nxt = FILL;
            FILL:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_cs     = (state == FILL);
        mem_addr   = {fill.tag, fill.idx, fill.cnt, 2'b00};
        inst_stall = (state == FILL) | miss;
        inst_data  = data_mem[a_idx][a_off];
    end

    // Control state; the fill target is latched so the fill ignores later
    // address changes from the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill     <= '0;
            pend     <= 1'b0;
            valid    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (flush) valid <= '0;
            case (state)
                IDLE: begin
                    if (miss) begin
                        fill     <= '{tag: a_tag, idx: a_idx, cnt: '0};
                        miss_cnt <= miss_cnt + 32'd1;
                    end else if (hit) begin
                        hit_cnt  <= hit_cnt + 32'd1;
                    end
                end
                FILL: begin
                    if (mem_ack) fill.cnt <= fill.cnt + O'(1);
                    // A flush seen at any point during the fill keeps this line invalid.
                    if (last) begin
                        valid[fill.idx] <= ~(pend | flush);
                        pend            <= 1'b0;
                    end else if (flush) begin
                        pend            <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            data_mem[fill.idx][fill.cnt] <= mem_din;
            if (last) tag_mem[fill.idx] <= fill.tag;
        end
    end
endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: expected fill addresses and fetch data are
// queued per request and popped as the DUT acks words or returns a hit.
module tb_inst_cache;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        flush;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_ack;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    inst_cache #(.LINE_WORDS(LW), .LINES(64)) dut (
        .clk(clk), .rst(rst),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
        .inst_stall(inst_stall), .flush(flush),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_q[$];
    logic [31:0] data_q[$];
    logic [31:0] exp_hit, exp_miss;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    endtask

    // One fetch held until served. nmiss line fills are expected; flush pulses on
    // cycle flush_at; rst_acks>0 asserts reset after that many acks and abandons the fetch.
    task automatic fetch(input logic [31:0] addr, input int period, input int exp_stall,
                         input int nmiss, input int flush_at, input int rst_acks);
        int stalls = 0;
        int per = 0;
        int acks = 0;
        logic [31:0] exp_d;
        for (int m = 0; m < nmiss; m++)
            for (int w = 0; w < LW; w++)
                mem_q.push_back((addr & ~32'(LW * 4 - 1)) + 32'(w * 4));
        data_q.push_back(addr);
        exp_miss = exp_miss + 32'(nmiss);
        @(negedge clk);
        inst_ren  = 1'b1;
        inst_addr = addr;
        for (int cyc = 0; ; cyc++) begin
            mem_ack = 1'b0;
            flush   = (cyc == flush_at);
            if (rst_acks != 0 && acks == rst_acks) begin
                rst = 1'b1;
                #1;
                chk("rst_mem_cs", 32'(mem_cs), 32'd0);
                chk("rst_hit_cnt", hit_cnt, 32'd0);
                chk("rst_miss_cnt", miss_cnt, 32'd0);
                mem_q.delete();
                data_q.delete();
                exp_hit  = '0;
                exp_miss = '0;
                inst_ren = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            #1;
            if (!inst_stall) break;
            if (cyc >= 200) begin
                chk("timeout", 32'(cyc), 32'd0);
                inst_ren = 1'b0;
                flush    = 1'b0;
                return;
            end
            stalls++;
            if (mem_cs) begin
                per++;
                if (mem_q.size() == 0) begin
                    chk("fill_expected", 32'(mem_q.size()), 32'd1);
                end else if (per == period) begin
                    mem_ack = 1'b1;
                    mem_din = mem_addr;
                    chk("mem_addr", mem_addr, mem_q.pop_front());
                    per = 0;
                    acks++;
                end else begin
                    chk("mem_addr_hold", mem_addr, mem_q[0]);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b0;
        exp_d = data_q.pop_front();
        chk("inst_data", inst_data, exp_d);
        chk("hit_mem_cs", 32'(mem_cs), 32'd0);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("fill_words_left", 32'(mem_q.size()), 32'd0);
        @(posedge clk);
        exp_hit = exp_hit + 32'd1;
        @(negedge clk);
        inst_ren = 1'b0;
        #1;
        chk("hit_cnt", hit_cnt, exp_hit);
        chk("miss_cnt", miss_cnt, exp_miss);
    endtask

    initial begin
        rst       = 1'b1;
        inst_ren  = 1'b0;
        inst_addr = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_din   = '0;
        exp_hit   = '0;
        exp_miss  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_mem_cs", 32'(mem_cs), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_hit_cnt", hit_cnt, 32'd0);
        chk("reset_miss_cnt", miss_cnt, 32'd0);
        chk("reset_stall_idle", 32'(inst_stall), 32'd0);
        inst_ren  = 1'b1;
        inst_addr = 32'h10;
        #1;
        chk("reset_stall_cold", 32'(inst_stall), 32'd1);
        inst_ren = 1'b0;

        // cold miss, then line reuse
        fetch(32'h10, 1, LW + 1, 1, -1, 0);
        fetch(32'h14, 1, 0, 0, -1, 0);
        fetch(32'h18, 1, 0, 0, -1, 0);
        fetch(32'h1C, 1, 0, 0, -1, 0);

        // conflict on index 1 with ack every 3rd cycle
        fetch(32'h410, 3, 1 + LW * 3, 1, -1, 0);
        fetch(32'h410, 1, 0, 0, -1, 0);
        fetch(32'h10, 1, LW + 1, 1, -1, 0);

        // flush in IDLE
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch(32'h10, 1, LW + 1, 1, -1, 0);

        // flush mid-fill: line stays invalid, held fetch refills it immediately
        fetch(32'h20, 1, 2 * (LW + 1), 2, 2, 0);
        fetch(32'h14, 1, LW + 1, 1, -1, 0);

        // reset after the 2nd ack, then the same line misses again
        fetch(32'h30, 1, 0, 1, -1, 2);
        fetch(32'h30, 1, LW + 1, 1, -1, 0);

        // hit counter wrap
        @(negedge clk);
        force dut.hit_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt;
        #1;
        chk("forced_hit_cnt", hit_cnt, 32'hFFFF_FFFF);
        exp_hit = 32'hFFFF_FFFF;
        fetch(32'h34, 1, 0, 0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the `mips_core` instruction fetch port (`inst_ren`/`inst_addr`/`inst_data`) and a slower word-wide instruction memory. Hits return the instruction combinationally in the same cycle. A miss asserts `inst_stall` toward the pipeline controller and runs a line-fill state machine that fetches the whole line word by word over a request/acknowledge handshake. The block also provides a synchronous flush and free-running hit/miss counters for the debug path.

## Interface
- `LINE_WORDS`, 4: words per line; power of two, at least 2.
- `LINES`, 64: number of lines; power of two.
- `clk`  in  1  main clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `inst_ren`  in  1  fetch request from the core.
- `inst_addr`  in  32  fetch byte address; bits [1:0] are ignored.
- `inst_data`  out  32  instruction word; valid when `inst_ren=1` and `inst_stall=0`.
- `inst_stall`  out  1  the core must hold its PC and IF/ID register while this is high.
- `flush`  in  1  invalidate all lines.
- `mem_cs`  out  1  word read request to instruction memory.
- `mem_addr`  out  32  word-aligned request address.
- `mem_din`  in  32  read data; valid in the cycle `mem_ack=1`.
- `mem_ack`  in  1  request accepted and data valid this cycle.
- `hit_cnt`  out  32  count of hit cycles.
- `miss_cnt`  out  32  count of misses.

## Operation
- **Address split** (O = log2(LINE_WORDS), I = log2(LINES)):
  - word offset = addr[O+1:2]
  - index = addr[O+I+1:O+2]
  - tag = addr[31:O+I+2]
  - With the default parameters: offset [3:2], index [9:4], tag [31:10].
- **Storage**:
  - Per line: a valid bit, a tag, and LINE_WORDS data words.
  - Reset and flush clear the valid bits only. Data and tag contents are don't-care.
- **hit** = `inst_ren` & valid[index] & (tag[index] == tag).
- **States**:
  - IDLE: `mem_cs=0`.
    - `inst_ren` & !hit: latch the line's tag and index, clear the word counter, increment `miss_cnt`, go to FILL.
    - `inst_ren` & hit: increment `hit_cnt`.
  - FILL: `mem_cs=1`, `mem_addr` = {latched tag, latched index, counter, 2'b00}.
    - On `mem_ack`: write `mem_din` to word[counter] of the latched line and increment the counter.
    - On `mem_ack` with counter = LINE_WORDS-1: set the line's tag, set valid unless a flush is pending, clear the pending flush, go to IDLE.
    - No `mem_ack`: hold all state.
- **Stall**: `inst_stall` = (state == FILL) | (`inst_ren` & !hit). It is combinational.
- **`inst_data`**: the data word at [index][offset], combinational. Its value is don't-care while stalled or when `inst_ren=0`.
- **Flush**:
  - In IDLE: clears all valid bits at the clock edge. A hit in that same cycle is still served and counted.
  - In FILL: sets a pending flag. The remaining fill words are still written, but the line is not marked valid. All other valid bits are cleared immediately.
- **Address change mid-fill**: the fill always completes for the latched line; the current `inst_addr` is not used. The next IDLE cycle re-evaluates `inst_addr`.
- **Counters**: 32-bit and wrap from 0xFFFFFFFF to 0. They are not cleared by flush.

## Timing
- **Reset values**: state IDLE, all valid=0, counter=0, `mem_cs=0`, `mem_addr=0`, `hit_cnt=0`, `miss_cnt=0`, pending flush=0.
  - `inst_stall=0` while `inst_ren=0`.
  - `inst_stall=1` in the first cycle after reset if `inst_ren=1`, because every line is invalid.
- **Reset during FILL**: `mem_cs` drops asynchronously and the line stays invalid.
- **Hit latency**: 0 cycles (same cycle as the request).
- **Miss penalty with `mem_ack` held at 1**: `inst_stall` is high for LINE_WORDS+1 cycles.
  - Cycle 0: miss detected in IDLE.
  - Cycles 1..LINE_WORDS: FILL, one word per cycle.
  - Cycle LINE_WORDS+1: IDLE, hit, `inst_stall=0`.
- **Memory handshake**:
  - `mem_addr` is driven from registers and is stable while `mem_cs=1` and `mem_ack=0`.
  - Each `mem_ack` cycle consumes exactly one word.
- **Counter updates**: one increment per qualifying cycle. `hit_cnt` does not count during FILL.

## Test plan
- **Cold miss then hit**: after reset, `mem_ack`=1, `inst_ren`=1, addr 0x00000010, memory word = address.
  - `mem_addr` sequence 0x10, 0x14, 0x18, 0x1C.
  - Stall for 5 cycles, then `inst_data`=0x10.
  - `miss_cnt`=1, `hit_cnt` increments from the next cycle.
- **Line reuse**: after the first scenario, fetch 0x14, 0x18, 0x1C.
  - No stall; data equals the address.
  - `hit_cnt` increases by 3; `mem_cs` stays 0.
- **Conflict and wait states**: fetch 0x00000410 (same index as 0x10, different tag) with `mem_ack` high every 3rd cycle.
  - Stall for 1+4×3 cycles.
  - Afterwards 0x410 hits and 0x10 misses again.
- **Flush**:
  - `flush` pulse in IDLE, then fetch 0x10: a miss.
  - `flush` during FILL of 0x20: the fill completes (4 acks), then a re-fetch of 0x20 misses again.
- **Reset mid-fill**: assert `rst` after the 2nd ack.
  - `mem_cs`=0 immediately and the counters read 0.
  - After release, a fetch of the same address misses.
- **Counter wrap**: force `hit_cnt`=0xFFFFFFFF, then one hit: `hit_cnt`=0.
